// File: rtl/romulus_pkg.sv
// Romulus shared definitions: block geometry, packer FSM states,
// and the pad_n block padding used by the rho and tag stages.
package romulus_pkg;

  localparam int BLK_W     = 128;
  localparam int BLK_BYTES = 16;
  localparam int LEN_W     = 5;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_e;

  // Zero bytes len..14 and put len in the last byte; full blocks pass through.
  function automatic logic [BLK_W-1:0] pad_n(
    input logic [BLK_W-1:0] blk,
    input logic [LEN_W-1:0] len
  );
    logic [BLK_W-1:0] r;
    r = blk;
    if (len < LEN_W'(BLK_BYTES)) begin
      for (int k = 0; k < BLK_BYTES - 1; k++) begin
        if (k >= int'(len)) r[BLK_W-1-8*k -: 8] = 8'h00;
      end
      r[7:0] = 8'(len);
    end
    return r;
  endfunction

endpackage

// File: rtl/romulus_msg_packer.sv
// Romulus-N message packer: beats -> padded 128-bit blocks for rho,
// with an assembly register and an output register for full throughput.
module romulus_msg_packer
  import romulus_pkg::*;
#(
  parameter int IN_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic [IN_W-1:0]             in_data,
  input  logic [$clog2(IN_W/8):0]     in_bytes,
  input  logic                        in_last,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [BLK_W-1:0]            blk_data,
  output logic [LEN_W-1:0]            blk_len,
  output logic                        blk_last,
  output logic                        blk_partial,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic                        err
);

  localparam int NB = IN_W / 8;
  localparam int IB = $clog2(NB) + 1;
  localparam logic [IB-1:0] NB_V = IB'(NB);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(BLK_BYTES);

  pk_state_e        st_q, st_d;
  logic [BLK_W-1:0] asm_q;
  logic [LEN_W-1:0] off_q;
  logic             asm_last_q;
  logic             msg_start_q;
  logic             err_q;

  logic [BLK_W-1:0] ob_data_q;
  logic [LEN_W-1:0] ob_len_q;
  logic             ob_last_q;
  logic             ob_part_q;
  logic             ob_valid_q;

  logic             hold;
  logic             out_free;
  logic             acc;
  logic             mv_hold;
  logic [LEN_W-1:0] base_off;
  logic [BLK_W-1:0] base_data;
  logic             bad;
  logic             good;
  logic [LEN_W-1:0] new_off;
  logic [BLK_W-1:0] new_data;
  logic             close;
  logic [BLK_W-1:0] cls_data;
  logic             load_new;
  logic             to_hold;

  assign hold     = (st_q == HOLD);
  assign out_free = ~ob_valid_q | blk_ready;
  assign in_ready = rst_n & ~(hold & ob_valid_q & ~blk_ready);
  assign acc      = in_valid & in_ready;
  assign mv_hold  = hold & out_free;

  // A held block leaving this edge frees the assembly for the new beat.
  assign base_off  = hold ? '0 : off_q;
  assign base_data = hold ? '0 : asm_q;

  always_comb begin
    bad = 1'b0;
    if (in_bytes > NB_V) bad = 1'b1;
    if (in_bytes < NB_V && !in_last) bad = 1'b1;
    if (in_bytes == '0 &&
        !(in_last && base_off == '0 && msg_start_q))
      bad = 1'b1;
  end

  assign good    = acc & ~bad;
  assign new_off = base_off + LEN_W'(in_bytes);

  always_comb begin
    new_data = base_data;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(in_bytes) &&
          int'(base_off) + i < BLK_BYTES)
        new_data[BLK_W-1-8*(int'(base_off)+i) -: 8] =
          in_data[IN_W-1-8*i -: 8];
    end
  end

  assign close    = good & ((new_off == FULL) | in_last);
  assign cls_data = pad_n(new_data, new_off);
  assign load_new = close & ~hold & out_free;
  assign to_hold  = close & ~load_new;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      FILL: st_d = to_hold ? HOLD : FILL;
      HOLD: st_d = (to_hold | ~mv_hold) ? HOLD : FILL;
      default: st_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= FILL;
      asm_q       <= '0;
      off_q       <= '0;
      asm_last_q  <= 1'b0;
      msg_start_q <= 1'b1;
      err_q       <= 1'b0;
      ob_data_q   <= '0;
      ob_len_q    <= '0;
      ob_last_q   <= 1'b0;
      ob_part_q   <= 1'b0;
      ob_valid_q  <= 1'b0;
    end else if (clr) begin
      st_q        <= FILL;
      asm_q       <= '0;
      off_q       <= '0;
      asm_last_q  <= 1'b0;
      msg_start_q <= 1'b1;
      err_q       <= 1'b0;
      ob_data_q   <= '0;
      ob_len_q    <= '0;
      ob_last_q   <= 1'b0;
      ob_part_q   <= 1'b0;
      ob_valid_q  <= 1'b0;
    end else begin
      st_q <= st_d;

      if (mv_hold) begin
        ob_data_q  <= asm_q;
        ob_len_q   <= off_q;
        ob_last_q  <= asm_last_q;
        ob_part_q  <= (off_q != FULL);
        ob_valid_q <= 1'b1;
      end else if (load_new) begin
        ob_data_q  <= cls_data;
        ob_len_q   <= new_off;
        ob_last_q  <= in_last;
        ob_part_q  <= (new_off != FULL);
        ob_valid_q <= 1'b1;
      end else if (blk_ready) begin
        ob_valid_q <= 1'b0;
      end

      if (to_hold) begin
        asm_q      <= cls_data;
        off_q      <= new_off;
        asm_last_q <= in_last;
      end else if (load_new) begin
        asm_q      <= '0;
        off_q      <= '0;
        asm_last_q <= 1'b0;
      end else if (good) begin
        asm_q      <= new_data;
        off_q      <= new_off;
      end else if (mv_hold) begin
        asm_q      <= '0;
        off_q      <= '0;
        asm_last_q <= 1'b0;
      end

      if (acc) msg_start_q <= close & in_last;
      if (acc & bad) err_q <= 1'b1;
    end
  end

  assign blk_data    = ob_data_q;
  assign blk_len     = ob_len_q;
  assign blk_last    = ob_last_q;
  assign blk_partial = ob_part_q;
  assign blk_valid   = ob_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_romulus_msg_packer.sv
// Directed bench for romulus_msg_packer (IN_W=32): full, partial, empty,
// backpressure, protocol-error and reset scenarios.
module tb_romulus_msg_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] blk_data;
  logic [4:0]   blk_len;
  logic         blk_last;
  logic         blk_partial;
  logic         blk_valid;
  logic         blk_ready;
  logic         err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [127:0] d;
    logic [4:0]   l;
    logic         la;
    logic         p;
  } blk_t;

  blk_t q[$];

  romulus_msg_packer #(.IN_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_data(in_data), .in_bytes(in_bytes),
    .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .blk_data(blk_data),
    .blk_len(blk_len), .blk_last(blk_last),
    .blk_partial(blk_partial),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && blk_valid && blk_ready)
      q.push_back('{blk_data, blk_len, blk_last, blk_partial});
  end

  task automatic send_beat(input logic [31:0] d,
                           input logic [2:0] b,
                           input logic l);
    int n;
    @(negedge clk);
    in_data = d; in_bytes = b; in_last = l; in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL accept_timeout data=%h in_ready=%b want 1",
               d, in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_data = '0; in_bytes = '0; in_last = 1'b0;
    blk_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_ready got=%b want 0", in_ready);
    end
    checks++;
    if ({blk_valid, blk_last, blk_partial, err} !== 4'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b want 0000",
               {blk_valid, blk_last, blk_partial, err});
    end
    checks++;
    if (blk_data !== 128'h0 || blk_len !== 5'd0) begin
      failures++;
      $display("FAIL rst_data got=%h/%0d want 0/0",
               blk_data, blk_len);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_rst_ready got=%b want 1", in_ready);
    end
  endtask

  task automatic test_full_blocks;
    logic [31:0] d;
    q.delete();
    blk_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      send_beat(d, 3'd4, i == 7);
      #1;
      if (i == 2) begin
        checks++;
        if (blk_valid !== 1'b0) begin
          failures++;
          $display("FAIL full_early_valid got=%b want 0", blk_valid);
        end
      end
      if (i == 3) begin
        checks++;
        if (blk_valid !== 1'b1 || blk_data !==
            128'h000102030405060708090a0b0c0d0e0f) begin
          failures++;
          $display("FAIL full_blk0 v=%b d=%h want 1/0001..0f",
                   blk_valid, blk_data);
        end
      end
      if (i == 7) begin
        checks++;
        if (blk_valid !== 1'b1 || blk_data !==
            128'h101112131415161718191a1b1c1d1e1f) begin
          failures++;
          $display("FAIL full_blk1 v=%b d=%h want 1/1011..1f",
                   blk_valid, blk_data);
        end
      end
    end
    idle(3);
    checks++;
    if (q.size() != 2) begin
      failures++;
      $display("FAIL full_count got=%0d want 2", q.size());
    end else begin
      checks++;
      if (q[0].l !== 5'd16 || q[0].p !== 1'b0 ||
          q[0].la !== 1'b0) begin
        failures++;
        $display("FAIL full_b0_meta got=%0d/%b/%b want 16/0/0",
                 q[0].l, q[0].p, q[0].la);
      end
      checks++;
      if (q[1].l !== 5'd16 || q[1].p !== 1'b0 ||
          q[1].la !== 1'b1) begin
        failures++;
        $display("FAIL full_b1_meta got=%0d/%b/%b want 16/0/1",
                 q[1].l, q[1].p, q[1].la);
      end
    end
  endtask

  task automatic test_partial;
    q.delete();
    send_beat(32'hAABBCCDD, 3'd4, 1'b0);
    send_beat(32'h11223344, 3'd3, 1'b1);
    idle(3);
    checks++;
    if (q.size() != 1) begin
      failures++;
      $display("FAIL part_count got=%0d want 1", q.size());
    end else begin
      checks++;
      if (q[0].d !== 128'hAABBCCDD11223300_0000000000000007) begin
        failures++;
        $display("FAIL part_data got=%h want aabbccdd112233..07",
                 q[0].d);
      end
      checks++;
      if (q[0].l !== 5'd7 || q[0].p !== 1'b1 || q[0].la !== 1'b1) begin
        failures++;
        $display("FAIL part_meta got=%0d/%b/%b want 7/1/1",
                 q[0].l, q[0].p, q[0].la);
      end
    end
  endtask

  task automatic test_empty_msg;
    q.delete();
    send_beat(32'hDEADBEEF, 3'd0, 1'b1);
    idle(3);
    checks++;
    if (q.size() != 1) begin
      failures++;
      $display("FAIL empty_count got=%0d want 1", q.size());
    end else begin
      checks++;
      if (q[0].d !== 128'h0 || q[0].l !== 5'd0 ||
          q[0].p !== 1'b1 || q[0].la !== 1'b1) begin
        failures++;
        $display("FAIL empty_blk got=%h/%0d/%b/%b want 0/0/1/1",
                 q[0].d, q[0].l, q[0].p, q[0].la);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL empty_err got=%b want 0", err);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] exp;
    logic [31:0] d;
    q.delete();
    blk_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = {8'(8'h20+4*i), 8'(8'h21+4*i),
           8'(8'h22+4*i), 8'(8'h23+4*i)};
      send_beat(d, 3'd4, 1'b0);
    end
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_in_ready got=%b want 0", in_ready);
    end
    checks++;
    if (blk_valid !== 1'b1 ||
        blk_data !== 128'h202122232425262728292a2b2c2d2e2f) begin
      failures++;
      $display("FAIL bp_hold_data v=%b d=%h want 1/2021..2f",
               blk_valid, blk_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    blk_ready = 1'b1;
    for (int i = 8; i < 12; i++) begin
      d = {8'(8'h20+4*i), 8'(8'h21+4*i),
           8'(8'h22+4*i), 8'(8'h23+4*i)};
      send_beat(d, 3'd4, i == 11);
    end
    idle(4);
    checks++;
    if (q.size() != 3) begin
      failures++;
      $display("FAIL bp_count got=%0d want 3", q.size());
    end else begin
      for (int b = 0; b < 3; b++) begin
        for (int k = 0; k < 16; k++)
          exp[127-8*k -: 8] = 8'(8'h20 + 16*b + k);
        checks++;
        if (q[b].d !== exp || q[b].la !== (b == 2)) begin
          failures++;
          $display("FAIL bp_blk%0d got=%h/%b want %h/%b",
                   b, q[b].d, q[b].la, exp, b == 2);
        end
      end
    end
    checks++;
    if (blk_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained got=%b want 0", blk_valid);
    end
  endtask

  task automatic test_proto_err;
    q.delete();
    send_beat(32'h01020304, 3'd4, 1'b0);
    send_beat(32'h05060708, 3'd2, 1'b0);
    idle(3);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_set got=%b want 1", err);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL err_no_blk got=%0d want 0", q.size());
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clr got=%b want 0", err);
    end
    send_beat(32'hEEFF9999, 3'd2, 1'b1);
    idle(3);
    checks++;
    if (q.size() != 1) begin
      failures++;
      $display("FAIL clr_count got=%0d want 1", q.size());
    end else begin
      checks++;
      if (q[0].d !== 128'hEEFF0000_00000000_00000000_00000002 ||
          q[0].l !== 5'd2) begin
        failures++;
        $display("FAIL clr_blk got=%h/%0d want eeff..02/2",
                 q[0].d, q[0].l);
      end
    end
  endtask

  task automatic test_mid_reset;
    q.delete();
    send_beat(32'h99999999, 3'd4, 1'b0);
    send_beat(32'h88888888, 3'd4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, blk_valid, err} !== 3'b000 ||
        blk_data !== 128'h0) begin
      failures++;
      $display("FAIL mrst_outs got=%b/%h want 000/0",
               {in_ready, blk_valid, err}, blk_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(32'h55667788, 3'd4, 1'b1);
    idle(3);
    checks++;
    if (q.size() != 1) begin
      failures++;
      $display("FAIL mrst_count got=%0d want 1", q.size());
    end else begin
      checks++;
      if (q[0].d !== 128'h55667788_00000000_00000000_00000004 ||
          q[0].l !== 5'd4 || q[0].la !== 1'b1) begin
        failures++;
        $display("FAIL mrst_blk got=%h/%0d/%b want 5566..04/4/1",
                 q[0].d, q[0].l, q[0].la);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_blocks();
    test_partial();
    test_empty_msg();
    test_backpressure();
    test_proto_err();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
